// File: rtl/sad_err_sweep_ctrl.sv
// sad_err_sweep_ctrl: sweeps vectors through an external sad_i10_o3 and accumulates
// error statistics of its result against the exact pair-XOR population count.
module sad_err_sweep_ctrl #(
  parameter int         NUM_VEC = 1024,
  parameter bit         RANDOM  = 1'b0,
  parameter logic [9:0] SEED    = 10'h2A5,
  parameter int         CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [9:0]       dut_pi,
  input  logic [2:0]       dut_po,
  output logic [CNT_W-1:0] vec_idx,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W+2:0] err_sum,
  output logic [2:0]       err_max,
  output logic [9:0]       wce_vec
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [9:0]       FIRST = RANDOM ? ((SEED == 10'h000) ? 10'h001 : SEED) : 10'h000;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_VEC - 1);
  state_t           state_q, state_d;
  logic [9:0]       pi_q, pi_d, wce_q, wce_d, pi_nxt;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [CNT_W+2:0] sum_q, sum_d;
  logic [2:0]       max_q, max_d, exact, err;
  always_comb begin
    exact = 3'd0;
    for (int k = 0; k < 5; k++) exact = exact + {2'b00, pi_q[2*k] ^ pi_q[2*k+1]};
    err    = (dut_po >= exact) ? dut_po - exact : exact - dut_po;
    pi_nxt = RANDOM ? {pi_q[8:0], pi_q[9] ^ pi_q[6]} : pi_q + 10'd1;
  end
  always_comb begin
    state_d = state_q;
    pi_d    = pi_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    wce_d   = wce_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pi_d    = FIRST;
        idx_d   = '0;
        cnt_d   = '0;
        sum_d   = '0;
        max_d   = '0;
        wce_d   = '0;
      end
      RUN: begin
        idx_d = idx_q + CNT_W'(1);
        cnt_d = cnt_q + CNT_W'(err != 3'd0);
        sum_d = sum_q + (CNT_W+3)'(err);
        if (err > max_q) begin
          max_d = err;
          wce_d = pi_q;
        end
        // the last sample leaves the final vector on the bus
        if (idx_q == LAST) state_d = DONE;
        else pi_d = pi_nxt;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pi_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      wce_q   <= '0;
    end else begin
      state_q <= state_d;
      pi_q    <= pi_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      wce_q   <= wce_d;
    end
  end
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign dut_pi  = pi_q;
  assign vec_idx = idx_q;
  assign err_cnt = cnt_q;
  assign err_sum = sum_q;
  assign err_max = max_q;
  assign wce_vec = wce_q;
endmodule
